inst_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the multi-cycle core; produces the core's `inst` input from the core's `PC` output.
- On a fetch request, it latches the PC and issues a word read to instruction memory over a req/gnt/rvalid handshake.
- It holds the returned word stable on `inst` until the next fetch, so the core can sample it in its decode cycle.
- Misaligned PCs and memory timeouts substitute a NOP (all-zero word) and raise an error flag.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_timeout_ctr.sv | 18 +
 rtl/inst_fetch.sv | 69 ++++++
 tb/tb_inst_fetch.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, NOP word and default timeout for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: clearable saturating counter; tc high when cnt reaches LAST (clk, rst, clr, en -> tc)
module fetch_timeout_ctr #(
  parameter int CNT_W = 4,
  parameter logic [CNT_W-1:0] LAST = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 1'b1;
  assign tc = cnt == LAST;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: latches pc on fetch_req, reads one word over req/gnt/rvalid, holds it on inst; NOP + fetch_err on misalignment or timeout
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              fetch_err,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t state;
  logic tc, accept, fin, quit;
  assign accept = fetch_req && (state == IDLE || state == DONE);
  assign fin = (state == REQ && mem_gnt && mem_rvalid) || (state == WAIT && mem_rvalid);
  assign quit = busy && tc && !fin;
  fetch_timeout_ctr #(.CNT_W(CNT_W), .LAST(CNT_W'(TIMEOUT - 1))) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(busy),
    .tc(tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      inst       <= FETCH_NOP;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else if (accept) begin
      mem_addr <= pc;
      if (pc[1:0] != 2'b00) begin
        state      <= DONE;
        inst       <= FETCH_NOP;
        inst_valid <= 1'b1;
        fetch_err  <= 1'b1;
      end else begin
        state      <= REQ;
        mem_req    <= 1'b1;
        busy       <= 1'b1;
        inst_valid <= 1'b0;
        fetch_err  <= 1'b0;
      end
    end else if (fin || quit) begin
      state      <= DONE;
      inst       <= fin ? mem_rdata : FETCH_NOP;
      inst_valid <= 1'b1;
      fetch_err  <= !fin;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
    end else if (state == REQ && mem_gnt) begin
      state   <= WAIT;
      mem_req <= 1'b0;
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table-driven and randomized check of inst_fetch against an outcome model
module tb_inst_fetch;
  localparam int TO = 15;
  logic clk = 0, rst = 1, fetch_req = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] pc = 0, mem_rdata = 0, inst, mem_addr;
  logic inst_valid, fetch_err, busy, mem_req;
  int total = 0, bad = 0;

  inst_fetch #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .inst(inst),
    .inst_valid(inst_valid), .fetch_err(fetch_err), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int g, r;
    logic [31:0] data, exp_inst;
    logic exp_err;
    int exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outcome of one fetch: memory grants in REQ cycle g and returns data in cycle r (r >= g),
  // counted from the first REQ cycle; lat = edges after the accepting edge until inst_valid.
  task automatic model(input logic [31:0] p, input int g, input int r, input logic [31:0] d,
                       output logic [31:0] ei, output logic ee, output int el, output int en);
    if (p[1:0] != 0) begin ei = 0; ee = 1; el = 0; en = 0; end
    else if (g > TO - 1) begin ei = 0; ee = 1; el = TO; en = TO; end
    else if (r <= TO - 1) begin ei = d; ee = 0; el = 1 + r; en = g + 1; end
    else begin ei = 0; ee = 1; el = TO; en = g + 1; end
  endtask

  task automatic run_fetch(input string name, input logic [31:0] p, input int g, input int r,
                           input logic [31:0] d, input bit poke);
    logic [31:0] ei;
    logic ee;
    int el, en, lat, k, nreq, nbusy, naddr;
    model(p, g, r, d, ei, ee, el, en);
    @(negedge clk);
    pc = p; fetch_req = 1; mem_gnt = 0; mem_rvalid = 0;
    @(posedge clk); #1;
    fetch_req = 0;
    lat = 0; k = 0; nreq = 0; nbusy = 0; naddr = 0;
    while (!inst_valid && lat < 40) begin
      mem_gnt = (k == g);
      mem_rvalid = (k == r);
      mem_rdata = (k == r) ? d : 32'hBAD0_BAD0;
      if (poke && k == 0) begin fetch_req = 1; pc = p + 32'h100; end
      if (mem_req) begin nreq++; if (mem_addr !== p) naddr++; end
      if (busy) nbusy++;
      @(posedge clk); #1;
      fetch_req = 0; lat++; k++;
    end
    mem_gnt = 0; mem_rvalid = 0;
    chk({name, " lat"}, lat, el);
    chk({name, " inst"}, inst, ei);
    chk({name, " err"}, fetch_err, ee);
    chk({name, " nreq"}, nreq, en);
    chk({name, " nbusy"}, nbusy, el);
    chk({name, " addr"}, naddr, 0);
    chk({name, " idle"}, {busy, mem_req}, 0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{32'h10, 0, 1, 32'h2, 32'h2, 0, 2};
    tbl[1] = '{32'h20, 4, 5, 32'hA5A5_0001, 32'hA5A5_0001, 0, 6};
    tbl[2] = '{32'h6, 0, 1, 32'h1, 32'h0, 1, 0};
    tbl[3] = '{32'h30, 0, 99, 32'h1, 32'h0, 1, 15};
    tbl[4] = '{32'h40, 0, 0, 32'h1234_5678, 32'h1234_5678, 0, 1};
    tbl[5] = '{32'h50, 99, 99, 32'h1, 32'h0, 1, 15};
    tbl[6] = '{32'h60, 0, 14, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 15};
    tbl[7] = '{32'h3, 0, 1, 32'h1, 32'h0, 1, 0};
    #12;
    chk("reset outs", {inst_valid, fetch_err, busy, mem_req}, 0);
    chk("reset inst", inst, 0);
    chk("reset addr", mem_addr, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 8; i++)
      run_fetch($sformatf("vec%0d", i), tbl[i].pc, tbl[i].g, tbl[i].r, tbl[i].data, 0);
    run_fetch("tmo", 32'h80, 1, 99, 32'h1, 0);
    @(negedge clk); mem_rvalid = 1; mem_gnt = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_rvalid = 0; mem_gnt = 0;
    @(negedge clk);
    chk("late inst", inst, 0);
    chk("late flags", {inst_valid, fetch_err, busy}, 3'b110);
    run_fetch("poke", 32'h90, 0, 0, 32'h1234_5678, 1);
    repeat (3) @(negedge clk);
    chk("poke hold", {busy, mem_req, inst_valid}, 3'b001);
    chk("poke inst", inst, 32'h1234_5678);
    @(negedge clk); pc = 32'hA0; fetch_req = 1;
    @(posedge clk); #1; fetch_req = 0; mem_gnt = 1;
    @(posedge clk); #1; mem_gnt = 0;
    chk("pre-rst wait", {busy, mem_req}, 2'b10);
    @(posedge clk); #3; rst = 1; #1;
    chk("async rst", {mem_req, inst_valid, busy, fetch_err}, 0);
    chk("async inst", inst, 0);
    @(negedge clk); rst = 0;
    run_fetch("post-rst", 32'hB0, 0, 1, 32'h0000_0777, 0);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] p;
      int g;
      p = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 3) == 0) p[1:0] = 2'($urandom_range(1, 3));
      g = $urandom_range(0, 16);
      run_fetch($sformatf("rnd%0d", i), p, g, g + $urandom_range(0, 16), $urandom, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
